uart_rx: RTL

//  8N1 UART receiver. Bit rate is set by a clock-count divider.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 35 +++
 rtl/uart_rx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Definitions shared by the UART receiver and transmitter:
//   - DEFAULT_CLOCKS_PER_BIT : default bit period in clk cycles
//   - uart_state_e           : 3-bit FSM state encoding
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  localparam int DEFAULT_CLOCKS_PER_BIT = 50;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } uart_state_e;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for the asynchronous serial line. Both flops reset
// to 1 (line idle) so a reset never looks like a start bit.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   rx_in   in  asynchronous serial input
//   rx_sync out synchronised serial line (2-cycle latency)
// -----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rx_sync
);

  logic rx_s1_q;
  logic rx_sync_q;

  // NOTE: sequential state is updated with non-blocking assignments so both
  // flops sample their inputs from the same clock edge and form a real chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_in;
      rx_sync_q <= rx_s1_q;
    end
  end

  assign rx_sync = rx_sync_q;

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. Detects the start bit on the synchronised line, samples
// each bit at mid-period using a clock-count divider and presents the byte
// with a one-cycle done strobe. A low stop bit discards the byte and pulses
// frame_err instead.
// Ports:
//   clk            in   system clock, all logic on posedge
//   rst            in   synchronous active-high reset
//   rx_in          in   asynchronous serial line, idle high
//   out_data_byte  out  last correctly framed byte (LSB received first)
//   rx_done        out  one-cycle pulse, out_data_byte just updated
//   frame_err      out  one-cycle pulse, stop bit sampled low
//   rx_busy        out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] out_data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  // Start-bit mid-point; derived, so it tracks CLOCKS_PER_BIT automatically.
  localparam int          HALF_BIT  = (CLOCKS_PER_BIT - 1) / 2;
  localparam logic [31:0] HALF_CNT  = 32'(HALF_BIT);
  localparam logic [31:0] LAST_CNT  = 32'(CLOCKS_PER_BIT - 1);

  logic        rx_sync;

  uart_state_e state_q,       state_d;
  logic [31:0] clock_count_q, clock_count_d;
  logic [2:0]  bit_index_q,   bit_index_d;
  logic [7:0]  shift_q,       shift_d;
  logic [7:0]  data_q,        data_d;
  logic        rx_done_q,     rx_done_d;
  logic        frame_err_q,   frame_err_d;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx_in   (rx_in),
    .rx_sync (rx_sync)
  );

  // Next-state and datapath logic.
  // NOTE: every signal gets a default before the case statement so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    clock_count_d = clock_count_q;
    bit_index_d   = bit_index_q;
    shift_d       = shift_q;
    data_d        = data_q;
    rx_done_d     = 1'b0;
    frame_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        clock_count_d = '0;
        bit_index_d   = '0;
        if (!rx_sync) state_d = ST_START;
      end

      ST_START: begin
        if (clock_count_q == HALF_CNT) begin
          clock_count_d = '0;
          bit_index_d   = '0;
          // Line back high at mid-start means a glitch, not a frame.
          state_d       = rx_sync ? ST_IDLE : ST_DATA;
        end else begin
          clock_count_d = clock_count_q + 32'd1;
        end
      end

      ST_DATA: begin
        if (clock_count_q == LAST_CNT) begin
          clock_count_d         = '0;
          shift_d[bit_index_q]  = rx_sync;
          // 3-bit index wraps 7->0 exactly as the last bit is taken.
          bit_index_d           = bit_index_q + 3'd1;
          if (bit_index_q == 3'd7) state_d = ST_STOP;
        end else begin
          clock_count_d = clock_count_q + 32'd1;
        end
      end

      ST_STOP: begin
        if (clock_count_q == LAST_CNT) begin
          clock_count_d = '0;
          if (rx_sync) begin
            data_d    = shift_q;
            rx_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = ST_CLEANUP;
        end else begin
          clock_count_d = clock_count_q + 32'd1;
        end
      end

      ST_CLEANUP: begin
        // A stuck-low (break) line must not retrigger a new frame.
        if (rx_sync) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      clock_count_q <= '0;
      bit_index_q   <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      rx_done_q     <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      clock_count_q <= clock_count_d;
      bit_index_q   <= bit_index_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      rx_done_q     <= rx_done_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign out_data_byte = data_q;
  assign rx_done       = rx_done_q;
  assign frame_err     = frame_err_q;
  assign rx_busy       = (state_q != ST_IDLE);

endmodule : uart_rx
